// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared bus types and constants for the MIPS memory bus.
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  localparam int WORD_W = 32;
  localparam int LANES = WORD_W / 8;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
endpackage

// File: rtl/avalon_mem_responder_if.sv
// avalon_mem_responder_if: Avalon-MM request/response bundle between CPU and memory.
interface avalon_mem_responder_if;
  import mips_bus_pkg::*;
  logic [31:0] address;
  logic read;
  logic write;
  logic [LANES-1:0] byteenable;
  logic [WORD_W-1:0] writedata;
  logic waitrequest;
  logic [WORD_W-1:0] readdata;
  logic error;
  modport master(output address, read, write, byteenable, writedata, input waitrequest, readdata, error);
  modport slave(input address, read, write, byteenable, writedata, output waitrequest, readdata, error);
endinterface

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: replaces the enabled byte lanes of an old word with the new word.
module byte_lane_merge
  import mips_bus_pkg::*;
(
  input  logic [WORD_W-1:0] i_old,
  input  logic [WORD_W-1:0] i_new,
  input  logic [LANES-1:0]  i_be,
  output logic [WORD_W-1:0] o_merged
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign o_merged[8*i +: 8] = i_be[i] ? i_new[8*i +: 8] : i_old[8*i +: 8];
  end
endmodule

// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: Avalon-MM memory slave with programmable wait states and byte-enabled writes.
module avalon_mem_responder
  import mips_bus_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input logic clk,
  input logic reset,
  avalon_mem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [WORD_W-1:0] r_mem [DEPTH];
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx, w_ack_idx;
  logic r_mis, r_is_wr, w_mis, w_ack_mis, w_ack_wr;
  logic [LANES-1:0] r_be;
  logic [WORD_W-1:0] r_wdata, r_readdata, w_merged;
  logic r_error, w_req, w_both, w_drop, w_wait, w_unused;

  assign w_req  = bus.read ^ bus.write;
  assign w_both = bus.read & bus.write;
  assign w_drop = !bus.read && !bus.write;
  assign w_idx  = bus.address[ADDR_WIDTH+1:2];
  assign w_mis  = |bus.address[1:0];
  assign w_unused = ^bus.address[31:ADDR_WIDTH+2];

  assign w_ack_idx = (r_state == IDLE) ? w_idx : r_idx;
  assign w_ack_mis = (r_state == IDLE) ? w_mis : r_mis;
  assign w_ack_wr  = (r_state == IDLE) ? bus.write : r_is_wr;

  always_comb begin
    w_next = r_state;
    w_wait = 1'b0;
    w_next = (r_state == IDLE) ? (w_req ? ((WAIT_CYCLES == 1) ? ACK : BUSY) : IDLE)
           : (r_state == BUSY) ? (w_drop ? IDLE : ((r_cnt == 4'd1) ? ACK : BUSY))
           : IDLE;
    w_wait = reset && ((r_state == BUSY) || (r_state == IDLE && w_req));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_mis      <= 1'b0;
      r_is_wr    <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_readdata <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_idx   <= w_idx;
        r_mis   <= w_mis;
        r_is_wr <= bus.write;
        r_be    <= bus.byteenable;
        r_wdata <= bus.writedata;
        r_cnt   <= 4'(WAIT_CYCLES - 1);
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if ((r_state == IDLE && (w_both || (w_req && w_mis))) || (r_state == BUSY && w_drop))
        r_error <= 1'b1;
      if (w_next == ACK && r_state != ACK && !w_ack_wr)
        r_readdata <= w_ack_mis ? '0 : r_mem[w_ack_idx];
    end
  end

  byte_lane_merge u_merge (
    .i_old   (r_mem[r_idx]),
    .i_new   (r_wdata),
    .i_be    (r_be),
    .o_merged(w_merged)
  );

  always_ff @(posedge clk) begin
    if (r_state == ACK && r_is_wr && !r_mis) r_mem[r_idx] <= w_merged;
  end

  assign bus.waitrequest = w_wait;
  assign bus.readdata    = r_readdata;
  assign bus.error       = r_error;
endmodule

// File: tb/tb_avalon_mem_responder.sv
// tb_avalon_mem_responder: randomized checks of the memory responder against a word-array model.
module tb_avalon_mem_responder;
  localparam int AW = 6;
  localparam int W = 2;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_pass = 0;
  int n_chk = 0;
  logic [31:0] exp_mem [DEPTH];
  logic exp_err = 1'b0;

  avalon_mem_responder_if bus();

  avalon_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W), .INIT_FILE("")) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Reference: memory is a plain word array indexed by (byte address / 4) mod depth
  function automatic logic [31:0] model(input logic [31:0] a, input logic rd, input logic [3:0] be, input logic [31:0] wd);
    int idx;
    idx = int'((a >> 2) % DEPTH);
    if (a % 4 != 0) begin
      exp_err = 1'b1;
      return 32'h0;
    end
    if (rd) return exp_mem[idx];
    exp_mem[idx] = merge(exp_mem[idx], wd, be);
    return 32'h0;
  endfunction

  task automatic xfer(input logic [31:0] a, input logic rd, input logic [3:0] be, input logic [31:0] wd,
                      output int nw, output logic [31:0] rdat);
    bus.address = a;
    bus.read = rd;
    bus.write = !rd;
    bus.byteenable = be;
    bus.writedata = wd;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.waitrequest) break;
      nw++;
      @(posedge clk); #1;
    end
    rdat = bus.readdata;
    @(posedge clk); #1;
    bus.read = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.address = '0; bus.byteenable = '0; bus.writedata = '0;
    do_reset();
    @(negedge clk);
    n_chk++; if (bus.waitrequest !== 1'b0) $display("FAIL reset_wait: got %b expected 0", bus.waitrequest); else n_pass++;
    n_chk++; if (bus.readdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", bus.readdata); else n_pass++;
    n_chk++; if (bus.error !== 1'b0) $display("FAIL reset_error: got %b expected 0", bus.error); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    int nw, bad;
    logic [31:0] r, d;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      r = model(32'(i * 4), 1'b0, 4'hF, d);
      xfer(32'(i * 4), 1'b0, 4'hF, d, nw, r);
      if (nw != W) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL fill_wait: got %0d bad transfers expected 0", bad); else n_pass++;
  endtask

  task automatic test_basic_read();
    int nw;
    logic [31:0] r, e;
    r = model(32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
    xfer(32'h10, 1'b0, 4'hF, 32'hDEADBEEF, nw, r);
    e = model(32'h10, 1'b1, 4'h0, 32'h0);
    xfer(32'h10, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (nw !== W) $display("FAIL read_wait: got %0d expected %0d", nw, W); else n_pass++;
    n_chk++; if (r !== e) $display("FAIL read_data: got %h expected %h", r, e); else n_pass++;
    n_chk++; if (e !== 32'hDEADBEEF) $display("FAIL read_model: got %h expected deadbeef", e); else n_pass++;
    n_chk++; if (bus.error !== 1'b0) $display("FAIL read_error: got %b expected 0", bus.error); else n_pass++;
  endtask

  task automatic test_byte_lanes();
    int nw;
    logic [31:0] r, e;
    r = model(32'h8, 1'b0, 4'hF, 32'hAABBCCDD);
    xfer(32'h8, 1'b0, 4'hF, 32'hAABBCCDD, nw, r);
    r = model(32'h8, 1'b0, 4'b0101, 32'h11223344);
    xfer(32'h8, 1'b0, 4'b0101, 32'h11223344, nw, r);
    e = model(32'h8, 1'b1, 4'h0, 32'h0);
    xfer(32'h8, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (r !== 32'hAA22CC44) $display("FAIL byte_lanes: got %h expected aa22cc44", r); else n_pass++;
    r = model(32'h8, 1'b0, 4'b0000, 32'hFFFFFFFF);
    xfer(32'h8, 1'b0, 4'b0000, 32'hFFFFFFFF, nw, r);
    xfer(32'h8, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (r !== e) $display("FAIL be_zero: got %h expected %h", r, e); else n_pass++;
  endtask

  task automatic test_random();
    int nw, bad_w, bad_d;
    logic rd;
    logic [31:0] a, r, e, d;
    logic [3:0] be;
    bad_w = 0; bad_d = 0;
    for (int i = 0; i < 80; i++) begin
      a = {$urandom_range(0, 255) == 0 ? 24'h0 : 24'($urandom), 6'($urandom), 2'b00};
      rd = 1'($urandom);
      be = 4'($urandom);
      d = $urandom;
      e = model(a, rd, be, d);
      xfer(a, rd, be, d, nw, r);
      if (nw != W) bad_w++;
      if (rd && r !== e) begin
        bad_d++;
        $display("FAIL rand_read: addr %h got %h expected %h", a, r, e);
      end
    end
    n_chk++; if (bad_w != 0) $display("FAIL rand_wait: got %0d bad transfers expected 0", bad_w); else n_pass++;
    n_chk++; if (bad_d != 0) $display("FAIL rand_data: got %0d bad reads expected 0", bad_d); else n_pass++;
    n_chk++; if (bus.error !== exp_err) $display("FAIL rand_error: got %b expected %b", bus.error, exp_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nw;
    logic [31:0] r;
    r = model(32'h0C, 1'b0, 4'hF, 32'hCAFEF00D);
    xfer(32'h0C, 1'b0, 4'hF, 32'hCAFEF00D, nw, r);
    xfer(32'h0C, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (r !== 32'hCAFEF00D) $display("FAIL b2b_read: got %h expected cafef00d", r); else n_pass++;
    n_chk++; if (nw !== W) $display("FAIL b2b_wait: got %0d expected %0d", nw, W); else n_pass++;
    xfer(32'h10C, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (r !== 32'hCAFEF00D) $display("FAIL alias_read: got %h expected cafef00d", r); else n_pass++;
  endtask

  task automatic test_both_high();
    int nw, bad;
    logic [31:0] r, e;
    n_chk++; if (bus.error !== 1'b0) $display("FAIL both_pre_error: got %b expected 0", bus.error); else n_pass++;
    bus.address = 32'h14; bus.writedata = 32'h0BADF00D; bus.byteenable = 4'hF;
    bus.read = 1'b1; bus.write = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.waitrequest !== 1'b0) $display("FAIL both_wait: got %b expected 0", bus.waitrequest); else n_pass++;
    @(posedge clk); #1;
    bus.read = 1'b0; bus.write = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.error !== 1'b1) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL both_sticky: got %0d cycles without error expected 0", bad); else n_pass++;
    @(posedge clk); #1;
    e = model(32'h14, 1'b1, 4'h0, 32'h0);
    xfer(32'h14, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (r !== e) $display("FAIL both_nowrite: got %h expected %h", r, e); else n_pass++;
    do_reset();
    @(negedge clk);
    n_chk++; if (bus.error !== 1'b0) $display("FAIL error_clear: got %b expected 0", bus.error); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    int nw;
    logic [31:0] r, e;
    e = model(32'h06, 1'b1, 4'h0, 32'h0);
    xfer(32'h06, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (nw !== W) $display("FAIL mis_wait: got %0d expected %0d", nw, W); else n_pass++;
    n_chk++; if (r !== e) $display("FAIL mis_rdata: got %h expected %h", r, e); else n_pass++;
    n_chk++; if (bus.error !== exp_err) $display("FAIL mis_error: got %b expected %b", bus.error, exp_err); else n_pass++;
    do_reset();
    r = model(32'h07, 1'b0, 4'hF, 32'h12345678);
    xfer(32'h07, 1'b0, 4'hF, 32'h12345678, nw, r);
    n_chk++; if (bus.error !== exp_err) $display("FAIL mis_wr_error: got %b expected %b", bus.error, exp_err); else n_pass++;
    do_reset();
    e = model(32'h04, 1'b1, 4'h0, 32'h0);
    xfer(32'h04, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (r !== e) $display("FAIL mis_wr_suppress: got %h expected %h", r, e); else n_pass++;
  endtask

  task automatic test_abort();
    logic [31:0] e;
    e = bus.readdata;
    bus.address = 32'h18; bus.read = 1'b1; bus.write = 1'b0;
    @(posedge clk); #1;
    bus.read = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (bus.waitrequest !== 1'b0) $display("FAIL abort_wait: got %b expected 0", bus.waitrequest); else n_pass++;
    n_chk++; if (bus.error !== 1'b1) $display("FAIL abort_error: got %b expected 1", bus.error); else n_pass++;
    n_chk++; if (bus.readdata !== e) $display("FAIL abort_rdata: got %h expected %h", bus.readdata, e); else n_pass++;
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_reset_mid();
    int nw;
    logic [31:0] r, e;
    r = model(32'h20, 1'b0, 4'hF, 32'h13572468);
    xfer(32'h20, 1'b0, 4'hF, 32'h13572468, nw, r);
    e = model(32'h20, 1'b1, 4'h0, 32'h0);
    xfer(32'h20, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (r !== e) $display("FAIL pre_reset_read: got %h expected %h", r, e); else n_pass++;
    bus.address = 32'h20; bus.writedata = 32'hFFFFFFFF; bus.byteenable = 4'hF;
    bus.read = 1'b0; bus.write = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (bus.waitrequest !== 1'b1) $display("FAIL mid_busy_wait: got %b expected 1", bus.waitrequest); else n_pass++;
    #1 reset = 1'b0;
    bus.write = 1'b0;
    #1;
    n_chk++; if (bus.waitrequest !== 1'b0) $display("FAIL mid_reset_wait: got %b expected 0", bus.waitrequest); else n_pass++;
    n_chk++; if (bus.readdata !== 32'h0) $display("FAIL mid_reset_rdata: got %h expected 0", bus.readdata); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_err = 1'b0;
    xfer(32'h20, 1'b1, 4'h0, 32'h0, nw, r);
    n_chk++; if (r !== e) $display("FAIL mid_reset_drop: got %h expected %h", r, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic_read();
    test_byte_lanes();
    test_random();
    test_back_to_back();
    test_both_high();
    test_misaligned();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
